alu_seq: RTL and testbench

//   Parametrised, handshaked successor to the single-cycle ALU. Keeps the existing 4-bit op

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 106 ++++++++++
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the handshaked sequential ALU (alu_seq).
//   Contents:
//     OP_*        4-bit operation codes (legacy single-cycle encoding plus
//                 XOR, signed SLT, MUL, DIVU and REMU)
//     state_t     handshake FSM state encoding (S_IDLE, S_BUSY, S_DONE)
//     is_iterative  true when an op needs the multi-cycle mul/div unit
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIVU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_REMU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Divide by zero takes the single-cycle fast path, so only a real
    // division (or any multiply) goes through the iterative unit.
    function automatic logic is_iterative(input logic [3:0] op, input logic b_is_zero);
        return (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
//   Iterative shift-add multiplier (low WIDTH bits) and restoring unsigned
//   divider sharing one set of working registers. One iteration per clock,
//   WIDTH iterations per operation.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start          load operands and begin (one-cycle pulse)
//     op_sel         0 = multiply, 1 = divide
//     a, b           multiplicand/multiplier or dividend/divisor
//     busy           an operation is in progress
//     done           high during the final iteration cycle; the outputs
//                    then carry the final values and may be captured at
//                    the coming clock edge
//     prod_or_quot   product (multiply) or quotient (divide)
//     rem            remainder (divide)
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_or_quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic             div_mode;
    // Multiply: acc = partial product, shreg = multiplier, opnd = multiplicand.
    // Divide:   acc = partial remainder, shreg = dividend/quotient, opnd = divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] opnd_nxt;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // One iteration step. For the divider the partial remainder is always
    // below the divisor, so trial - divisor fits in WIDTH bits whenever it
    // does not borrow, and the borrow bit alone decides the quotient bit.
    always_comb begin
        acc_nxt  = acc;
        sh_nxt   = shreg;
        opnd_nxt = opnd;
        trial    = {acc, shreg[WIDTH-1]};
        diff     = trial - {1'b0, opnd};
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_nxt = diff[WIDTH-1:0];
                sh_nxt  = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = trial[WIDTH-1:0];
                sh_nxt  = {shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (shreg[0]) begin
                acc_nxt = acc + opnd;
            end
            sh_nxt   = shreg >> 1;
            opnd_nxt = opnd << 1;
        end
    end

    // Working registers and iteration counter. The last iteration's value is
    // presented combinationally so the caller sees it without an extra cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            cnt      <= '0;
            div_mode <= 1'b0;
            acc      <= '0;
            shreg    <= '0;
            opnd     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= '0;
            div_mode <= op_sel;
            acc      <= '0;
            shreg    <= op_sel ? a : b;
            opnd     <= op_sel ? b : a;
        end else if (busy) begin
            acc   <= acc_nxt;
            shreg <= sh_nxt;
            opnd  <= opnd_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done         = busy && (cnt == CW'(WIDTH - 1));
    assign prod_or_quot = div_mode ? sh_nxt : acc_nxt;
    assign rem          = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Handshaked multi-cycle ALU between decode and writeback. Simple ops
//   complete in one cycle; MUL/DIVU/REMU run WIDTH iterations in
//   alu_muldiv_iter and stall the core through in_ready.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid / in_ready   operation handshake (op, a, b latched on accept)
//     op, a, b              operation code (alu_pkg) and operands
//     out_valid / out_ready result handshake; outputs held until taken
//     result                registered result
//     zero                  result == 0
//     ovf                   signed overflow for ADD/SUB, else 0
//     dbz                   DIVU/REMU with b == 0
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             dbz
);

    state_t           state;
    logic [3:0]       op_q;
    logic             b_zero;
    logic             iter_op;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sub;
    logic [WIDTH-1:0] simple_res;
    logic             simple_ovf;
    logic             simple_dbz;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_pq;
    logic [WIDTH-1:0] md_rem;
    logic [WIDTH-1:0] md_res;

    assign b_zero  = (b == '0);
    assign iter_op = is_iterative(op, b_zero);
    // Gated by rst_n so upstream never sees a ready while the block is held in reset.
    assign in_ready = rst_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign sum      = a + b;
    assign sub      = a - b;

    // Single-cycle datapath, including the divide-by-zero fast path.
    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        simple_dbz = 1'b0;
        case (op)
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_XOR:  simple_res = a ^ b;
            OP_NOR:  simple_res = ~(a | b);
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = sub;
                simple_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_DIVU: begin
                simple_res = '1;
                simple_dbz = 1'b1;
            end
            OP_REMU: begin
                simple_res = a;
                simple_dbz = 1'b1;
            end
            default: simple_res = '0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept && iter_op),
        .op_sel       (op != OP_MUL),
        .a            (a),
        .b            (b),
        .busy         (md_busy),
        .done         (md_done),
        .prod_or_quot (md_pq),
        .rem          (md_rem)
    );

    assign md_res = (op_q == OP_REMU) ? md_rem : md_pq;

    // Handshake FSM and output registers. A new accept takes priority so a
    // DONE state with out_ready and in_valid flows straight into the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_AND;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            if (iter_op) begin
                state     <= S_BUSY;
                out_valid <= 1'b0;
            end else begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= simple_res;
                zero      <= (simple_res == '0);
                ovf       <= simple_ovf;
                dbz       <= simple_dbz;
            end
        end else if ((state == S_BUSY) && md_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= md_res;
            zero      <= (md_res == '0);
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end
    end

    // The iterative unit must be running for as long as the FSM waits on it.
    a_busy_tracks_fsm: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_BUSY) |-> md_busy);

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq (WIDTH = 32). Expected responses come
//   from a behavioural model and are queued at accept, then popped when the
//   DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIVU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_REMU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         d;
    } resp_t;

    typedef struct packed {
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } vec_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op        = 4'b0000;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         dbz;

    resp_t sb_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    vec_t simple_tbl [13] = '{
        '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001},
        '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001},
        '{OP_SUB,  32'h8000_0000, 32'h0000_0001},
        '{OP_SUB,  32'h0000_0005, 32'h0000_0005},
        '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001},
        '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001},
        '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF},
        '{OP_AND,  32'hF0F0_A5A5, 32'hFF00_FF00},
        '{OP_OR,   32'hF0F0_A5A5, 32'hFF00_FF00},
        '{OP_XOR,  32'hF0F0_A5A5, 32'hFF00_FF00},
        '{OP_NOR,  32'hF0F0_A5A5, 32'hFF00_FF00},
        '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0},
        '{4'b1010, 32'h1234_5678, 32'h9ABC_DEF0}
    };

    vec_t iter_tbl [13] = '{
        '{OP_MUL,  32'h0001_0000, 32'h0001_0000},
        '{OP_MUL,  32'h0000_0003, 32'h0000_0005},
        '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{OP_MUL,  32'h1234_5678, 32'h9ABC_DEF0},
        '{OP_MUL,  32'h0000_0000, 32'hDEAD_BEEF},
        '{OP_DIVU, 32'd100,       32'd7},
        '{OP_REMU, 32'd100,       32'd7},
        '{OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0000},
        '{OP_REMU, 32'h0000_1234, 32'h0000_0000},
        '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001},
        '{OP_DIVU, 32'd5,         32'd9},
        '{OP_REMU, 32'hFFFF_FFFF, 32'h0001_0000},
        '{OP_DIVU, 32'h8000_0000, 32'd3}
    };

    logic [3:0] simple_ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLTU, OP_NOR, OP_XOR, OP_SLT};

    alu_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Behavioural reference: plain operators, no iteration.
    function automatic resp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        resp_t          r;
        logic [2*W-1:0] p;
        r = '0;
        p = '0;
        case (o)
            OP_AND:  r.res = x & y;
            OP_OR:   r.res = x | y;
            OP_XOR:  r.res = x ^ y;
            OP_NOR:  r.res = ~(x | y);
            OP_ADD: begin
                r.res = x + y;
                r.v   = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            OP_SUB: begin
                r.res = x - y;
                r.v   = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
            end
            OP_SLTU: r.res = (x < y) ? 32'd1 : 32'd0;
            OP_SLT:  r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_MUL: begin
                p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r.res = p[W-1:0];
            end
            OP_DIVU: begin
                if (y == '0) begin
                    r.res = '1;
                    r.d   = 1'b1;
                end else begin
                    r.res = x / y;
                end
            end
            OP_REMU: begin
                if (y == '0) begin
                    r.res = x;
                    r.d   = 1'b1;
                end else begin
                    r.res = x % y;
                end
            end
            default: r.res = '0;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    function automatic resp_t next_expected();
        if (sb_q.size() == 0) begin
            return '1;
        end
        return sb_q.pop_front();
    endfunction

    // Presents an op and waits (bounded) for it to be accepted; returns just
    // after the accept edge with in_valid dropped, reporting cycles waited.
    task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output int waited);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        waited   = 0;
        #1;
        while (!in_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            sb_q.push_back(model(o, x, y));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({in_ready, out_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        vectors++;
        if ({result, zero, ovf, dbz} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: result=%h z=%b v=%b d=%b, required 0 1 0 0", result, zero, ovf, dbz);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_divu();
        int    w;
        int    stray;
        resp_t got;
        resp_t exp;
        out_ready = 1'b1;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, w);
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL divu_busy: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, zero, in_ready} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_divu: out_valid=%b zero=%b in_ready=%b, required 0 1 0", out_valid, zero, in_ready);
        end
        rst_n = 1'b1;
        sb_q.delete();
        #1;
        applyStimulus(OP_ADD, 32'd3, 32'd4, w);
        got = {result, zero, ovf, dbz};
        exp = next_expected();
        vectors++;
        if (!out_valid || got !== exp) begin
            miscompares++;
            $display("[TB] FAIL add_after_reset: valid=%b res=%h z=%b v=%b d=%b, required valid=1 res=%h z=%b v=%b d=%b",
                     out_valid, got.res, got.z, got.v, got.d, exp.res, exp.z, exp.v, exp.d);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            idle_cycle();
            if (out_valid) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL discarded_divu: out_valid seen %0d cycles after reset, required 0", stray);
        end
    endtask

    task automatic test_simple_ops();
        int    w;
        resp_t got;
        resp_t exp;
        out_ready = 1'b1;
        foreach (simple_tbl[i]) begin
            applyStimulus(simple_tbl[i].o, simple_tbl[i].x, simple_tbl[i].y, w);
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL simple_latency[%0d]: out_valid=%b one cycle after accept, required 1", i, out_valid);
            end
            got = {result, zero, ovf, dbz};
            exp = next_expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL simple[%0d] op=%b: res=%h z=%b v=%b d=%b, required res=%h z=%b v=%b d=%b",
                         i, simple_tbl[i].o, got.res, got.z, got.v, got.d, exp.res, exp.z, exp.v, exp.d);
            end
            idle_cycle();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL simple_drain[%0d]: out_valid=%b after handshake, required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_iterative();
        int    w;
        int    n;
        int    lat;
        logic  ir_seen;
        resp_t got;
        resp_t exp;
        out_ready = 1'b1;
        foreach (iter_tbl[i]) begin
            lat = ((iter_tbl[i].o == OP_MUL) || (iter_tbl[i].y != '0)) ? W + 1 : 1;
            applyStimulus(iter_tbl[i].o, iter_tbl[i].x, iter_tbl[i].y, w);
            n       = 1;
            ir_seen = 1'b0;
            while (!out_valid && n < 100) begin
                if (in_ready) ir_seen = 1'b1;
                @(posedge clk);
                #1;
                n++;
            end
            vectors++;
            if (n != lat || ir_seen) begin
                miscompares++;
                $display("[TB] FAIL iter_latency[%0d] op=%b: latency=%0d in_ready_while_busy=%b, required %0d and 0",
                         i, iter_tbl[i].o, n, ir_seen, lat);
            end
            got = {result, zero, ovf, dbz};
            exp = next_expected();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("[TB] FAIL iter[%0d] op=%b: res=%h z=%b v=%b d=%b, required res=%h z=%b v=%b d=%b",
                         i, iter_tbl[i].o, got.res, got.z, got.v, got.d, exp.res, exp.z, exp.v, exp.d);
            end
            idle_cycle();
        end
    endtask

    task automatic test_backpressure();
        int    w;
        resp_t got;
        resp_t exp;
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'h0000_0011, 32'h0000_0022, w);
        exp = next_expected();
        op       = OP_SUB;
        a        = 32'h0000_0050;
        b        = 32'h0000_0008;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            got = {result, zero, ovf, dbz};
            vectors++;
            if (got !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold[%0d]: res=%h valid=%b in_ready=%b, required res=%h valid=1 in_ready=0",
                         c, got.res, out_valid, in_ready, exp.res);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        applyStimulus(OP_SUB, 32'h0000_0050, 32'h0000_0008, w);
        vectors++;
        if (w != 0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_accept: waited=%0d out_valid=%b, required 0 and 1", w, out_valid);
        end
        got = {result, zero, ovf, dbz};
        exp = next_expected();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL release_result: res=%h z=%b v=%b d=%b, required res=%h z=%b v=%b d=%b",
                     got.res, got.z, got.v, got.d, exp.res, exp.z, exp.v, exp.d);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int         w;
        int         n;
        logic [3:0] o;
        resp_t      got;
        resp_t      exp;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = simple_ops[$urandom_range(0, 7)];
            applyStimulus(o, $urandom, (i == 3) ? 32'h0 : $urandom, w);
            got = {result, zero, ovf, dbz};
            exp = next_expected();
            vectors++;
            if (w != 0 || out_valid !== 1'b1 || got !== exp) begin
                miscompares++;
                $display("[TB] FAIL b2b[%0d] op=%b: waited=%0d valid=%b res=%h z=%b v=%b, required 0 1 res=%h z=%b v=%b",
                         i, o, w, out_valid, got.res, got.z, got.v, exp.res, exp.z, exp.v);
            end
        end
        applyStimulus(OP_MUL, 32'd7, 32'd6, w);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        got = {result, zero, ovf, dbz};
        exp = next_expected();
        vectors++;
        if (w != 0 || n != W + 1 || got !== exp) begin
            miscompares++;
            $display("[TB] FAIL b2b_mul: waited=%0d latency=%0d res=%h, required 0 %0d res=%h",
                     w, n, got.res, W + 1, exp.res);
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_divu();
        test_simple_ops();
        test_iterative();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guards against a stuck handshake taking the run down silently.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
